// File: rtl/vending_pkg.sv
// vending_pkg: shared FSM state type, default price table and price-slice helper
// for the multi-item vending controller.
package vending_pkg;
    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
    localparam int DEF_NUM_ITEMS = 4;
    localparam int DEF_CREDIT_W = 8;
    localparam logic [31:0] DEF_PRICES = {8'd12, 8'd10, 8'd8, 8'd5};
    localparam int STOCK_W = 4;
    // Extract the idx-th w-bit field of a packed table (item 0 in the LSBs).
    function automatic logic [31:0] price_slice(input logic [1023:0] tbl, input int unsigned idx,
                                                input int unsigned w);
        logic [1023:0] s;
        s = tbl >> (idx * w);
        return s[31:0] & ((32'd1 << w) - 32'd1);
    endfunction
endpackage

// File: rtl/vending_stock.sv
// vending_stock: per-item stock counters with restock-to-full and registered
// sold-out flags; a restock overrides a decrement of the same item.
module vending_stock import vending_pkg::*; #(
    parameter int NUM_ITEMS = DEF_NUM_ITEMS,
    parameter int SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_restock_valid,
    input  logic [SEL_W-1:0]     i_restock_idx,
    input  logic                 i_dec_valid,
    input  logic [SEL_W-1:0]     i_dec_idx,
    output logic [NUM_ITEMS-1:0] o_sold_out
);
    logic [STOCK_W-1:0] r_cnt [NUM_ITEMS];
    logic [STOCK_W-1:0] w_cnt_nxt [NUM_ITEMS];
    logic [NUM_ITEMS-1:0] r_sold_out;

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            w_cnt_nxt[i] = (i_restock_valid && 32'(i_restock_idx) == i) ? '1 :
                           (i_dec_valid && 32'(i_dec_idx) == i && r_cnt[i] != 0) ? r_cnt[i] - 1'b1 :
                           r_cnt[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) r_cnt[i] <= '0;
            r_sold_out <= '1;
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
                r_sold_out[i] <= w_cnt_nxt[i] == 0;
            end
        end
    end

    assign o_sold_out = r_sold_out;
endmodule

// File: rtl/vending_ctrl_multi.sv
// vending_ctrl_multi: N-item vending controller with coin accumulation, cancel,
// exact change and registered handshakes. STOCK_COUNT_EN adds per-item stock tracking.
module vending_ctrl_multi import vending_pkg::*; #(
    parameter int NUM_ITEMS = DEF_NUM_ITEMS,
    parameter int COIN_W = 4,
    parameter int CREDIT_W = DEF_CREDIT_W,
    parameter int MAX_CREDIT = 20,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = DEF_PRICES,
    localparam int SEL_W = NUM_ITEMS > 1 ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_coin_valid,
    input  logic [COIN_W-1:0]    i_coin_value,
    input  logic                 i_sel_valid,
    input  logic [SEL_W-1:0]     i_sel_idx,
    input  logic                 i_cancel,
    output logic [NUM_ITEMS-1:0] o_push,
    output logic                 o_refund_valid,
    output logic [CREDIT_W-1:0]  o_refund,
    output logic [CREDIT_W-1:0]  o_credit,
    output logic                 o_coin_reject,
    output logic                 o_no_funds,
    output logic                 o_busy
`ifdef STOCK_COUNT_EN
    ,
    input  logic                 i_restock_valid,
    input  logic [SEL_W-1:0]     i_restock_idx,
    output logic [NUM_ITEMS-1:0] o_sold_out
`endif
);
    state_t r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt, r_refund, w_refund_nxt, w_price;
    logic [CREDIT_W-1:0] w_prices [NUM_ITEMS];
    logic [CREDIT_W:0] w_sum;
    logic [NUM_ITEMS-1:0] r_push, w_push_nxt;
    logic r_refund_valid, w_refund_valid_nxt, r_coin_reject, w_coin_reject_nxt;
    logic r_no_funds, w_no_funds_nxt, r_busy;
    logic w_open, w_sel_ok, w_cancel, w_sel, w_vend, w_coin_ok, w_in_stock;

    genvar g;
    for (g = 0; g < NUM_ITEMS; g++) begin : g_price
        assign w_prices[g] = CREDIT_W'(price_slice(1024'(PRICES), g, CREDIT_W));
    end

    // Priority in IDLE/CREDIT: cancel > selection > coin; a pre-empted coin is rejected.
    assign w_open = r_state == IDLE || r_state == CREDIT;
    assign w_sel_ok = 32'(i_sel_idx) < NUM_ITEMS;
    assign w_price = w_sel_ok ? w_prices[i_sel_idx] : '0;
    assign w_cancel = i_cancel && r_state == CREDIT;
    assign w_sel = w_open && i_sel_valid && w_sel_ok && !w_cancel;
    assign w_vend = w_sel && w_in_stock && r_credit >= w_price;
    assign w_sum = {1'b0, r_credit} + (CREDIT_W+1)'(i_coin_value);
    assign w_coin_ok = w_open && i_coin_valid && !w_cancel && !w_sel &&
                       w_sum <= (CREDIT_W+1)'(MAX_CREDIT);

`ifdef STOCK_COUNT_EN
    logic [NUM_ITEMS-1:0] w_sold_out;
    vending_stock #(.NUM_ITEMS(NUM_ITEMS), .SEL_W(SEL_W)) u_stock (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_restock_valid (i_restock_valid),
        .i_restock_idx   (i_restock_idx),
        .i_dec_valid     (w_vend),
        .i_dec_idx       (i_sel_idx),
        .o_sold_out      (w_sold_out)
    );
    assign w_in_stock = !w_sold_out[i_sel_idx];
    assign o_sold_out = w_sold_out;
`else
    assign w_in_stock = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, CREDIT: w_state_nxt = w_cancel ? CHANGE : w_vend ? VEND :
                                        (w_coin_ok && w_sum != 0) ? CREDIT : r_state;
            VEND:         w_state_nxt = CHANGE;
            default:      w_state_nxt = IDLE;
        endcase
    end

    // Change is paid out on entry to CHANGE, so CHANGE always exits to IDLE.
    always_comb begin
        w_credit_nxt = w_state_nxt == CHANGE ? '0 : w_vend ? r_credit - w_price :
                       w_coin_ok ? w_sum[CREDIT_W-1:0] : r_credit;
        w_refund_valid_nxt = w_state_nxt == CHANGE && r_credit != 0;
        w_refund_nxt = w_refund_valid_nxt ? r_credit : '0;
        w_push_nxt = w_vend ? (NUM_ITEMS'(1) << i_sel_idx) : '0;
        w_coin_reject_nxt = i_coin_valid && !w_coin_ok;
        w_no_funds_nxt = w_sel && !w_vend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_credit <= '0;
            r_push <= '0;
            r_refund_valid <= 1'b0;
            r_refund <= '0;
            r_coin_reject <= 1'b0;
            r_no_funds <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_push <= w_push_nxt;
            r_refund_valid <= w_refund_valid_nxt;
            r_refund <= w_refund_nxt;
            r_coin_reject <= w_coin_reject_nxt;
            r_no_funds <= w_no_funds_nxt;
            r_busy <= w_state_nxt == VEND || w_state_nxt == CHANGE;
        end
    end

    assign o_push = r_push;
    assign o_refund_valid = r_refund_valid;
    assign o_refund = r_refund;
    assign o_credit = r_credit;
    assign o_coin_reject = r_coin_reject;
    assign o_no_funds = r_no_funds;
    assign o_busy = r_busy;
endmodule
